rx_frame_ctrl: RTL and testbench

Receive-frame controller that sequences the nibble-to-byte converter on the PHY receive path. It gates the converter's enable from the PHY data-valid line and consumes the converter's byte strobe. It validates preamble and SFD, delimits payload with start/end markers, enforces length limits and inter-frame gap, and exports a clean byte stream with per-frame error codes and saturating statistics to the downstream frame buffer.

---
 rtl/rx_frame_pkg.sv | 39 +++
 rtl/rx_frame_ctrl_sat_cnt.sv | 18 +
 rtl/rx_frame_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the receive-frame controller.
package rx_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        DROP,
        GAP
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_ALIGN = 2'd1;
    localparam logic [1:0] ERR_RUNT  = 2'd2;
    localparam logic [1:0] ERR_LONG  = 2'd3;

    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    localparam int unsigned PRE_CNT_W = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic [1:0] err;
    } out_beat_t;

    // End-of-frame code for a normally terminated frame: align beats runt.
    function automatic logic [1:0] end_code(input logic odd, input logic runt);
        if (odd)
            return ERR_ALIGN;
        else if (runt)
            return ERR_RUNT;
        else
            return ERR_NONE;
    endfunction

endpackage

// File: rtl/rx_frame_ctrl_sat_cnt.sv
// Saturating up-counter with increment enable.
module sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive-frame controller: gates the nibble converter, checks preamble/SFD,
// delimits payload with a one-byte hold stage and reports per-frame status.
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter int unsigned PRE_MIN  = 7,
    parameter int unsigned MIN_LEN  = 64,
    parameter int unsigned MAX_LEN  = 1518,
    parameter int unsigned IDLE_GAP = 12
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx_dv,
    output logic        conv_ena,
    input  logic        conv_ren,
    input  logic [7:0]  conv_data,
    input  logic        conv_err,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic [1:0]  out_err,
    output logic        busy,
    output logic [15:0] ok_cnt,
    output logic [15:0] bad_cnt
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 2);
    localparam int unsigned GAP_W = $clog2(IDLE_GAP + 1);

    state_t                 state_q, state_d;
    logic [PRE_CNT_W-1:0]   pre_q, pre_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [7:0]             hold_q, hold_d;
    logic                   hold_vld_q, hold_vld_d;
    logic                   parity_q, parity_d;
    logic                   eof_pend_q, eof_pend_d;
    logic                   first_q, first_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic                   dv_q;
    out_beat_t              beat_q, beat_d;
    logic                   ov_q, ov_d;
    logic                   busy_q, busy_d;
    logic                   ok_inc, bad_inc;
    logic                   push, flush;
    logic [1:0]             flush_code;
    logic                   runt;

    assign runt = 32'(len_q) < MIN_LEN;

    // Combinational so the converter sees enable alongside the nibble.
    assign conv_ena = rx_dv && ((state_q == IDLE) || (state_q == PREAMBLE) ||
                                (state_q == PAYLOAD));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= GAP;
            pre_q      <= '0;
            len_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            parity_q   <= 1'b0;
            eof_pend_q <= 1'b0;
            first_q    <= 1'b0;
            gap_q      <= '0;
            // A stream already running at reset release is not a new start.
            dv_q       <= 1'b1;
            beat_q     <= '0;
            ov_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            len_q      <= len_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            parity_q   <= parity_d;
            eof_pend_q <= eof_pend_d;
            first_q    <= first_d;
            gap_q      <= gap_d;
            dv_q       <= rx_dv;
            beat_q     <= beat_d;
            ov_q       <= ov_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        len_d      = len_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        parity_d   = parity_q;
        eof_pend_d = eof_pend_q;
        first_d    = first_q;
        gap_d      = gap_q;
        beat_d     = beat_q;
        ov_d       = 1'b0;
        ok_inc     = 1'b0;
        bad_inc    = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        flush_code = ERR_NONE;

        case (state_q)
            IDLE: begin
                if (rx_dv) begin
                    state_d = PREAMBLE;
                    pre_d   = '0;
                end
            end
            PREAMBLE: begin
                if (conv_err) begin
                    state_d = DROP;
                    bad_inc = 1'b1;
                end else if (conv_ren) begin
                    if (conv_data == PRE_BYTE) begin
                        if (pre_q != '1)
                            pre_d = pre_q + 1'b1;
                    end else if ((conv_data == SFD_BYTE) && (32'(pre_q) >= PRE_MIN)) begin
                        state_d    = PAYLOAD;
                        len_d      = '0;
                        hold_vld_d = 1'b0;
                        parity_d   = 1'b0;
                        eof_pend_d = 1'b0;
                        first_d    = 1'b1;
                    end else begin
                        state_d = DROP;
                        bad_inc = 1'b1;
                    end
                end else if (!rx_dv) begin
                    state_d = GAP;
                    gap_d   = GAP_W'(1);
                    bad_inc = 1'b1;
                end
            end
            PAYLOAD: begin
                if (eof_pend_q) begin
                    // Last byte arrived with the falling rx_dv; flush it now.
                    flush      = 1'b1;
                    flush_code = end_code(parity_q, runt);
                    eof_pend_d = 1'b0;
                    state_d    = GAP;
                    gap_d      = rx_dv ? '0 : GAP_W'(1);
                end else begin
                    if (rx_dv)
                        parity_d = ~parity_q;
                    if (conv_ren) begin
                        if (len_q == LEN_W'(MAX_LEN)) begin
                            flush      = 1'b1;
                            flush_code = ERR_LONG;
                            state_d    = DROP;
                        end else begin
                            push       = hold_vld_q;
                            hold_d     = conv_data;
                            hold_vld_d = 1'b1;
                            len_d      = len_q + 1'b1;
                            eof_pend_d = !rx_dv;
                        end
                    end else if (!rx_dv) begin
                        state_d = GAP;
                        gap_d   = GAP_W'(1);
                        if (hold_vld_q) begin
                            flush      = 1'b1;
                            flush_code = end_code(parity_q, runt);
                        end else begin
                            bad_inc = 1'b1;
                        end
                    end
                end
            end
            DROP: begin
                if (!rx_dv) begin
                    state_d = GAP;
                    gap_d   = GAP_W'(1);
                end
            end
            GAP: begin
                if (rx_dv) begin
                    gap_d = '0;
                    if (!dv_q)
                        bad_inc = 1'b1;
                end else if (32'(gap_q) + 32'd1 >= IDLE_GAP) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = GAP;
        endcase

        if (push) begin
            ov_d    = 1'b1;
            beat_d  = '{data: hold_q, sof: first_q, eof: 1'b0, err: ERR_NONE};
            first_d = 1'b0;
        end
        if (flush) begin
            ov_d       = 1'b1;
            beat_d     = '{data: hold_q, sof: first_q, eof: 1'b1, err: flush_code};
            first_d    = 1'b0;
            hold_vld_d = 1'b0;
            if (flush_code == ERR_NONE)
                ok_inc = 1'b1;
            else
                bad_inc = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    assign out_valid = ov_q;
    assign out_data  = beat_q.data;
    assign out_sof   = beat_q.sof;
    assign out_eof   = beat_q.eof;
    assign out_err   = beat_q.err;
    assign busy      = busy_q;

    sat_cnt #(.W(16)) u_ok_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (ok_inc),
        .count   (ok_cnt)
    );

    sat_cnt #(.W(16)) u_bad_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (bad_inc),
        .count   (bad_cnt)
    );

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Randomized frame stimulus for rx_frame_ctrl checked against a frame-level model.
module tb_rx_frame_ctrl;

    localparam int PRE_MIN  = 7;
    localparam int MIN_LEN  = 64;
    localparam int MAX_LEN  = 1518;

    logic        clock;
    logic        reset_n;
    logic        rx_dv;
    logic        conv_ena;
    logic        conv_ren;
    logic [7:0]  conv_data;
    logic        conv_err;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;
    logic [1:0]  out_err;
    logic        busy;
    logic [15:0] ok_cnt;
    logic [15:0] bad_cnt;

    int vectors    = 0;
    int miscompares = 0;
    int ok_exp     = 0;
    int bad_exp    = 0;

    logic [11:0] got_q[$];
    logic [11:0] exp_q[$];

    rx_frame_ctrl dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rx_dv     (rx_dv),
        .conv_ena  (conv_ena),
        .conv_ren  (conv_ren),
        .conv_data (conv_data),
        .conv_err  (conv_err),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_err   (out_err),
        .busy      (busy),
        .ok_cnt    (ok_cnt),
        .bad_cnt   (bad_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered outputs are stable at the falling edge.
    always @(negedge clock)
        if (reset_n && out_valid)
            got_q.push_back({out_data, out_sof, out_eof, out_err});

    initial begin
        #5000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic dv, input logic ren, input logic [7:0] d, input logic err);
        @(negedge clock);
        rx_dv     = dv;
        conv_ren  = ren;
        conv_data = d;
        conv_err  = err;
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic err, input bit chk_ena);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        if (chk_ena) begin
            #1;
            check("ena_start", 32'(conv_ena), 32'd1);
        end
        cyc(1'b1, 1'b1, b, err);
    endtask

    // sfd_mode: 0 good SFD, 1 wrong SFD byte, 2 rx_dv falls with no SFD.
    task automatic send_frame(input int npre, input int sfd_mode, input logic [7:0] sfd_bad,
                              input int n, input bit incr, input bit extra, input bit late,
                              input int err_idx, input int gap);
        logic [7:0] pl[$];
        bit         valid;
        int         m;
        logic [1:0] code;
        for (int i = 0; i < n; i++)
            pl.push_back(incr ? 8'(i) : 8'($urandom));
        valid = (sfd_mode == 0) && (npre >= PRE_MIN) && !(err_idx >= 0 && err_idx < npre);

        for (int i = 0; i < npre; i++)
            drive_byte(8'h55, 1'(i == err_idx), i == 0);
        if (sfd_mode != 2) begin
            drive_byte((sfd_mode == 0) ? 8'hD5 : sfd_bad, 1'b0, npre == 0);
            for (int i = 0; i < n; i++) begin
                if (late && i == n - 1) begin
                    cyc(1'b1, 1'b0, 8'h00, 1'b0);
                    cyc(1'b1, 1'b0, 8'h00, 1'b0);
                    cyc(1'b0, 1'b1, pl[i], 1'b0);
                end else begin
                    drive_byte(pl[i], 1'b0, 1'b0);
                end
            end
            if (extra)
                cyc(1'b1, 1'b0, 8'h00, 1'b0);
        end
        for (int i = 0; i < gap; i++)
            cyc(1'b0, 1'b0, 8'h00, 1'b0);

        if (!valid || sfd_mode == 2 || n == 0) begin
            bad_exp++;
        end else begin
            m = (n > MAX_LEN) ? MAX_LEN : n;
            if (n > MAX_LEN)      code = 2'd3;
            else if (extra)       code = 2'd1;
            else if (n < MIN_LEN) code = 2'd2;
            else                  code = 2'd0;
            for (int i = 0; i < m; i++)
                exp_q.push_back({pl[i], 1'(i == 0), 1'(i == m - 1),
                                 (i == m - 1) ? code : 2'd0});
            if (code == 2'd0) ok_exp++;
            else              bad_exp++;
        end
    endtask

    task automatic compare_frame(input string tag, input bit chk_bad);
        int k;
        check({tag, "_beats"}, 32'(got_q.size()), 32'(exp_q.size()));
        k = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < k; i++)
            check({tag, "_beat"}, 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, "_ok_cnt"}, 32'(ok_cnt), 32'(ok_exp));
        if (chk_bad)
            check({tag, "_bad_cnt"}, 32'(bad_cnt), 32'(bad_exp));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int         npre, mode, n, err_idx, gap, r;
        bit         extra, late;
        logic [7:0] sb;

        reset_n   = 1'b0;
        rx_dv     = 1'b0;
        conv_ren  = 1'b0;
        conv_data = 8'h00;
        conv_err  = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_flags", 32'({out_sof, out_eof, out_err}), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_ok",    32'(ok_cnt),    32'd0);
        check("rst_bad",   32'(bad_cnt),   32'd0);
        check("rst_ena",   32'(conv_ena),  32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("busy_gap", 32'(busy), 32'd1);
        repeat (18) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("busy_idle", 32'(busy), 32'd0);

        send_frame(7, 0, 8'h00, 64, 1'b1, 1'b0, 1'b0, -1, 16);
        compare_frame("good64", 1'b1);

        send_frame(3, 0, 8'h00, 0, 1'b0, 1'b0, 1'b0, -1, 12);
        compare_frame("short_pre", 1'b1);
        send_frame(7, 0, 8'h00, 20, 1'b0, 1'b0, 1'b0, -1, 16);
        compare_frame("after_gap12", 1'b1);

        send_frame(7, 0, 8'h00, 10, 1'b0, 1'b1, 1'b0, -1, 16);
        compare_frame("align", 1'b1);

        send_frame(8, 0, 8'h00, 1, 1'b0, 1'b0, 1'b0, -1, 16);
        compare_frame("one_byte", 1'b1);

        send_frame(7, 0, 8'h00, 70, 1'b0, 1'b0, 1'b1, -1, 16);
        compare_frame("late_last", 1'b1);

        send_frame(7, 0, 8'h00, 1600, 1'b0, 1'b0, 1'b0, -1, 16);
        check("long_idle", 32'(busy), 32'd0);
        compare_frame("long", 1'b1);

        send_frame(7, 0, 8'h00, 64, 1'b0, 1'b0, 1'b0, -1, 5);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'(i % 2), 8'($urandom), 1'b0);
            #1;
            check("ena_gap", 32'(conv_ena), 32'd0);
        end
        bad_exp++;
        repeat (16) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        compare_frame("lost_start", 1'b1);

        for (int f = 0; f < 25; f++) begin
            npre = $urandom_range(4, 10);
            r    = $urandom_range(0, 9);
            mode = (r < 6) ? 0 : (r < 8) ? 1 : 2;
            do sb = 8'($urandom); while (sb == 8'h55 || sb == 8'hD5);
            err_idx = ($urandom_range(0, 7) == 0) ? $urandom_range(0, npre - 1) : -1;
            n     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom_range(50, 90);
            extra = ($urandom_range(0, 3) == 0);
            late  = !extra && (n > 0) && ($urandom_range(0, 3) == 0);
            gap   = $urandom_range(16, 24);
            send_frame(npre, mode, sb, n, 1'b0, extra, late, err_idx, gap);
            compare_frame("rand", 1'b1);
        end

        for (int i = 0; i < 7; i++)
            drive_byte(8'h55, 1'b0, i == 0);
        drive_byte(8'hD5, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++)
            drive_byte(8'($urandom), 1'b0, 1'b0);
        @(negedge clock);
        reset_n  = 1'b0;
        rx_dv    = 1'b1;
        conv_ren = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_flags", 32'({out_sof, out_eof, out_err}), 32'd0);
        check("mid_rst_ena",   32'(conv_ena), 32'd0);
        check("mid_rst_ok",    32'(ok_cnt),   32'd0);
        check("mid_rst_bad",   32'(bad_cnt),  32'd0);
        got_q.delete();
        exp_q.delete();
        ok_exp = 0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++)
            drive_byte(8'($urandom), 1'b0, 1'b0);
        repeat (16) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_nosof", 32'(got_q.size()), 32'd0);
        send_frame(7, 0, 8'h00, 64, 1'b0, 1'b0, 1'b0, -1, 16);
        compare_frame("post_rst", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
